// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter
//   Round-robin arbiter that shares one external N-bit LFSR between R
//   requesters. The winner's seed is loaded into the LFSR and len
//   consecutive LFSR words are streamed back, tagged with the winner's id.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   req            per-requester request level
//   req_seed       seeds, requester i at [i*N +: N]
//   req_len        word counts, requester i at [i*LW +: LW]
//   grant          one-hot acceptance pulse (LOAD cycle)
//   lfsr_load_seed load strobe to the LFSR (LOAD cycle)
//   lfsr_seed_data seed to the LFSR, holds the captured seed otherwise
//   lfsr_data      current LFSR word
//   out_valid      output word valid
//   out_data       LFSR word gated by out_valid
//   out_id         id of the requester being served
//   out_last       final word of a burst
//   busy           high in LOAD and STREAM
module lfsr_arbiter #(
    parameter int N  = 4,
    parameter int R  = 4,
    parameter int LW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [R-1:0]         req,
    input  logic [R*N-1:0]       req_seed,
    input  logic [R*LW-1:0]      req_len,
    output logic [R-1:0]         grant,
    output logic                 lfsr_load_seed,
    output logic [N-1:0]         lfsr_seed_data,
    input  logic [N-1:0]         lfsr_data,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic [$clog2(R)-1:0] out_id,
    output logic                 out_last,
    output logic                 busy
);

    localparam int          IW  = $clog2(R);
    localparam int unsigned RU  = R;
    localparam logic [IW:0] R_W = (IW+1)'(R);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  id_r;
    logic [N-1:0]   seed_r;
    logic [LW-1:0]  len_r;
    logic [LW-1:0]  remaining;

    logic           win_any;
    logic [IW-1:0]  win_idx;
    logic [IW:0]    cand;

    // Scan upward from ptr+1 (mod R); the first set request wins, so the
    // previous winner (ptr itself) is examined last.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= RU; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= R_W)
                cand = cand - R_W;
            if (!win_any && req[cand[IW-1:0]]) begin
                win_any = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ptr            <= IW'(R-1);
            id_r           <= '0;
            seed_r         <= '0;
            len_r          <= '0;
            remaining      <= '0;
            grant          <= '0;
            lfsr_load_seed <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state          <= LOAD;
                        seed_r         <= req_seed[win_idx*N +: N];
                        len_r          <= req_len[win_idx*LW +: LW];
                        id_r           <= win_idx;
                        ptr            <= win_idx;
                        grant          <= '0;
                        grant[win_idx] <= 1'b1;
                        lfsr_load_seed <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                LOAD: begin
                    grant          <= '0;
                    lfsr_load_seed <= 1'b0;
                    if (len_r != '0) begin
                        state     <= STREAM;
                        remaining <= len_r;
                        out_valid <= 1'b1;
                        out_last  <= (len_r == LW'(1));
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (remaining == LW'(1)) begin
                        state     <= IDLE;
                        remaining <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        remaining <= remaining - LW'(1);
                        // out_last is registered, so it is raised one count early.
                        out_last  <= (remaining == LW'(2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lfsr_seed_data = seed_r;
    assign out_id         = id_r;
    assign out_data       = out_valid ? lfsr_data : '0;

endmodule

// File: tb/tb_lfsr_arbiter.sv
module tb_lfsr_arbiter;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int LW = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [R-1:0]      req = '0;
    logic [R*N-1:0]    req_seed = '0;
    logic [R*LW-1:0]   req_len = '0;
    logic [R-1:0]      grant;
    logic              lfsr_load_seed;
    logic [N-1:0]      lfsr_seed_data;
    logic [N-1:0]      lfsr_data;
    logic              out_valid;
    logic [N-1:0]      out_data;
    logic [IW-1:0]     out_id;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int model_ptr = R - 1;

    logic [N-1:0] lfsr_q = 4'h1;

    always #5 clk = ~clk;

    lfsr_arbiter #(.N(N), .R(R), .LW(LW)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_seed(req_seed),
        .req_len(req_len),
        .grant(grant),
        .lfsr_load_seed(lfsr_load_seed),
        .lfsr_seed_data(lfsr_seed_data),
        .lfsr_data(lfsr_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_id(out_id),
        .out_last(out_last),
        .busy(busy)
    );

    // Bench-side LFSR: x^4 + x^3 + 1, loads on load_seed, shifts otherwise.
    function automatic logic [N-1:0] lstep(input logic [N-1:0] q);
        return {q[N-2:0], q[N-1] ^ q[N-2]};
    endfunction

    always @(posedge clk) begin
        if (lfsr_load_seed)
            lfsr_q <= lfsr_seed_data;
        else
            lfsr_q <= lstep(lfsr_q);
    end
    assign lfsr_data = lfsr_q;

    // Round-robin reference: first set bit after the last winner, mod R.
    function automatic int pick(input logic [R-1:0] r, input int p);
        for (int i = 1; i <= R; i++) begin
            int c;
            c = (p + i) % R;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [N-1:0] s, input int len);
        req_seed[k*N +: N]   = s;
        req_len[k*LW +: LW]  = LW'(len);
        req[k]               = 1'b1;
    endtask

    // Entered in an IDLE cycle with req already driven; returns at the
    // negedge of the IDLE cycle that follows the burst.
    task automatic do_burst(input int k, input logic [N-1:0] seed, input int len,
                            input bit drop, input string tag);
        logic [R-1:0] g;
        logic [N-1:0] w;
        g = '0;
        g[k] = 1'b1;
        @(posedge clk);
        #1;
        if (drop) req[k] = 1'b0;
        model_ptr = k;
        @(negedge clk);
        checks++;
        if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_last, busy} !==
            {g, 1'b1, seed, 1'b0, 4'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL %s load: got grant=%b ld=%b sd=%h v=%b d=%h last=%b busy=%b; need grant=%b ld=1 sd=%h v=0 d=0 last=0 busy=1",
                     tag, grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_last, busy, g, seed);
        end
        w = seed;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy} !==
                {4'h0, 1'b0, seed, 1'b1, w, IW'(k), (i == len - 1), 1'b1}) begin
                failures++;
                $display("FAIL %s word%0d: got grant=%b ld=%b v=%b d=%h id=%0d last=%b busy=%b; need grant=0 ld=0 v=1 d=%h id=%0d last=%b busy=1",
                         tag, i, grant, lfsr_load_seed, out_valid, out_data, out_id, out_last, busy,
                         w, k, (i == len - 1));
            end
            w = lstep(w);
        end
        @(negedge clk);
        checks++;
        if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_last, busy} !==
            {4'h0, 1'b0, seed, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s idle: got grant=%b ld=%b sd=%h v=%b d=%h last=%b busy=%b; need all 0, sd=%h",
                     tag, grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_last, busy, seed);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        req = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_ptr = R - 1;
    endtask

    task automatic test_reset();
        req = '1;
        #1;
        checks++;
        if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy} !== '0) begin
            failures++;
            $display("FAIL reset_initial: got grant=%b ld=%b sd=%h v=%b d=%h id=%0d last=%b busy=%b; need all 0",
                     grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy} !== '0) begin
            failures++;
            $display("FAIL reset_held: got grant=%b ld=%b busy=%b v=%b; need all 0",
                     grant, lfsr_load_seed, busy, out_valid);
        end
        req = '0;
        reset = 1'b1;
        model_ptr = R - 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int k;
        set_req(0, 4'h9, 3);
        k = pick(req, model_ptr);
        do_burst(k, 4'h9, 3, 1'b1, "single");
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        reset_dut();
        for (int i = 0; i < R; i++) set_req(i, N'(4'h3 + i), 1);
        for (int i = 0; i < 5; i++) begin
            int k;
            k = order[i];
            do_burst(k, N'(4'h3 + k), 1, 1'b0, "contention");
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        int k;
        set_req(2, 4'hB, 0);
        k = pick(req, model_ptr);
        do_burst(k, 4'hB, 0, 1'b1, "zero_len");
        @(negedge clk);
        checks++;
        if ({lfsr_load_seed, out_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL zero_len_after: got ld=%b v=%b busy=%b; need 0 0 0",
                     lfsr_load_seed, out_valid, busy);
        end
    endtask

    task automatic test_ptr_wrap();
        int k;
        set_req(3, 4'h5, 2);
        k = pick(req, model_ptr);
        do_burst(k, 4'h5, 2, 1'b1, "wrap_pre");
        set_req(0, 4'hC, 1);
        set_req(3, 4'h7, 2);
        k = pick(req, model_ptr);
        do_burst(k, (k == 0) ? 4'hC : 4'h7, (k == 0) ? 1 : 2, 1'b1, "wrap_first");
        k = pick(req, model_ptr);
        do_burst(k, (k == 0) ? 4'hC : 4'h7, (k == 0) ? 1 : 2, 1'b1, "wrap_second");
    endtask

    task automatic test_reset_mid_stream();
        logic [N-1:0] s;
        logic [N-1:0] w;
        int k;
        s = N'($urandom_range(1, 15));
        set_req(2, s, 10);
        @(posedge clk);
        #1;
        req = '0;
        w = s;
        repeat (3) w = lstep(w);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_last} !== {1'b1, w, 1'b0}) begin
            failures++;
            $display("FAIL mid_stream_word4: got v=%b d=%h last=%b; need v=1 d=%h last=0",
                     out_valid, out_data, out_last, w);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy} !== '0) begin
            failures++;
            $display("FAIL mid_stream_reset: got grant=%b ld=%b sd=%h v=%b d=%h id=%0d last=%b busy=%b; need all 0",
                     grant, lfsr_load_seed, lfsr_seed_data, out_valid, out_data, out_id, out_last, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        model_ptr = R - 1;
        s = N'($urandom_range(1, 15));
        set_req(1, s, 3);
        k = pick(req, model_ptr);
        do_burst(k, s, 3, 1'b1, "after_reset");
    endtask

    task automatic test_max_len();
        int k;
        set_req(1, 4'h1, 15);
        k = pick(req, model_ptr);
        do_burst(k, 4'h1, 15, 1'b1, "max_len");
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL max_len_extra: got v=%b busy=%b; need 0 0", out_valid, busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int k;
            for (int i = 0; i < R; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    int len;
                    len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
                    set_req(i, N'($urandom), len);
                end
            end
            if (req == '0) set_req(int'($urandom_range(0, R-1)), N'($urandom), int'($urandom_range(0, 5)));
            k = pick(req, model_ptr);
            do_burst(k, req_seed[k*N +: N], int'(req_len[k*LW +: LW]), 1'b1, "random");
        end
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_len();
        test_ptr_wrap();
        test_reset_mid_stream();
        test_max_len();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Round-robin arbiter and sequencer that shares one N-bit LFSR between R requesters. A request carries a seed and a word count. The block grants one requester at a time, loads that requester's seed into the LFSR, and streams the requested number of consecutive LFSR words back, tagged with the requester id. It sits between the client blocks and the LFSR, and drives the LFSR's load_seed/seed_data inputs directly.

## Interface
- N, 4: LFSR width, 2..8
- R, 4: number of requesters, 2..8
- LW, 4: width of each word-count field
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  R  per-requester request level
- req_seed  in  R*N  seeds, requester i at [i*N +: N]
- req_len  in  R*LW  word counts, requester i at [i*LW +: LW]
- grant  out  R  one-hot, one-cycle acceptance pulse
- lfsr_load_seed  out  1  to LFSR load_seed
- lfsr_seed_data  out  N  to LFSR seed_data
- lfsr_data  in  N  from LFSR lfsr_data
- out_valid  out  1  output word valid
- out_data  out  N  LFSR word; 0 when out_valid=0
- out_id  out  clog2(R)  id of the requester being served
- out_last  out  1  marks the final word of a burst
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOAD, STREAM. Reset state is IDLE.
- IDLE, req==0: stay in IDLE.
- IDLE, any req bit set:
  - Select the winner k: the first set bit scanning upward from ptr+1, mod R.
  - Capture seed_r=req_seed[k], len_r=req_len[k], id_r=k.
  - Set ptr=k and go to LOAD.
- LOAD (exactly one cycle):
  - grant[k]=1, lfsr_load_seed=1, lfsr_seed_data=seed_r.
  - Next state is STREAM if len_r!=0, otherwise IDLE.
- STREAM:
  - out_valid=1, out_data=lfsr_data, out_id=id_r.
  - Decrement remaining each cycle, starting from len_r.
  - out_last=1 when remaining==1; the following state is IDLE.
- The LFSR shifts every cycle it is not loading. The stream is therefore seed, then step1, step2, and so on.
- req_len=0: the request is still granted and the LFSR is loaded, but no words are output.
- Requester rules:
  - Drop req in the grant cycle or earlier.
  - A req still high when the block returns to IDLE is treated as a new request.
  - req_seed and req_len must be stable only in the IDLE cycle where they are sampled.
- Fairness: the winner of a burst has the lowest priority in the next arbitration. Reset ptr=R-1, so requester 0 wins first.
- lfsr_seed_data holds seed_r outside LOAD; its value there is don't-care to the LFSR.
- Reset values:
  - grant=0, lfsr_load_seed=0, lfsr_seed_data=0
  - out_valid=0, out_data=0, out_id=0, out_last=0, busy=0
  - seed_r=0, len_r=0, remaining=0, ptr=R-1
- All control outputs are registered.
- out_data is lfsr_data gated by out_valid.

## Timing
- Request sampled in IDLE at cycle t:
  - grant and lfsr_load_seed are high in cycle t+1.
  - The first out_valid is in cycle t+2, with out_data equal to the seed.
  - The last word is in cycle t+1+len.
- Back-to-back bursts: one IDLE bubble after out_last, then LOAD. The minimum period per burst is len+2 cycles.
- Simultaneous requests are resolved in a single IDLE cycle, with no extra latency.
- New requests arriving during LOAD or STREAM wait. They are arbitrated in the next IDLE cycle.
- reset low at any point, including mid-LOAD or mid-STREAM:
  - All outputs go to their reset values immediately and asynchronously.
  - The burst is abandoned, and no out_last is produced for it.
  - Operation resumes from IDLE on the first clk edge after reset goes high.
- busy rises in LOAD, the cycle after sampling. It falls in the cycle after out_last (IDLE), or after LOAD when len=0.
- The maximum burst length is 2^LW-1 words. No wrap-around is possible, because remaining only counts down to 0.

## Test plan
- Single request: req=0001, seed0=4'h9, len0=3.
  - grant=0001 for exactly one cycle, with lfsr_load_seed=1 and lfsr_seed_data=4'h9.
  - Then three out_valid words with out_id=0; the first is 4'h9 and the next two match the LFSR step model.
  - out_last is high on the third word only, and busy returns to 0.
- Contention: req=1111 held, each with len=1.
  - Grants occur in the order 0,1,2,3,0 with periods of 3 cycles.
  - out_id follows the same order, and no requester is granted twice before the others.
- Zero length: req=0100, len2=0.
  - grant=0100 for one cycle and one lfsr_load_seed pulse.
  - out_valid stays 0, and the block is back in IDLE two cycles after sampling.
- Pointer wrap: after serving requester 3, assert req=1001.
  - Requester 0 wins first, then requester 3.
- Reset mid-stream: len=10; drive reset low on the 4th word.
  - All outputs are 0 within the same cycle.
  - After release, req=0010 is granted with ptr at reset (requester 0 first) and the normal latency of 2 cycles to the first word.
- Max length: len=4'hF with seed 4'h1.
  - Exactly 15 words are produced, out_last is on the 15th, and there are no extra out_valid cycles.
